div_seq_ctrl: RTL
=================

// Module: div_seq_ctrl
// PURPOSE
//   Multi-cycle sequencer for signed 32-bit division: restoring shift/subtract, one quotient bit per clock.
//   Sits between the control unit and the HI/LO registers and replaces the single-cycle combinational divide path.
//   Latches operands on start, iterates, applies sign fix-up.
//   Returns quotient->LO and remainder->HI with a one-cycle done/write-enable pulse.
// PARAMETERS
//   WIDTH   32   operand/result width (two's complement); iteration count = WIDTH
// PORTS
//   clock      in   1      rising-edge clock
//   clear      in   1      asynchronous, active-low reset
//   start      in   1      request; accepted only in IDLE or DONE state
//   flush      in   1      synchronous abort; wins over start in same cycle
//   dividend   in   WIDTH  signed, sampled on accepting edge only
//   divisor    in   WIDTH  signed, sampled on accepting edge only
//   busy       out  1      high from accept edge until done edge (exclusive)
//   done       out  1      one-cycle pulse, results valid
//   lo_en      out  1      = done; LO write enable
//   hi_en      out  1      = done; HI write enable
//   quotient   out  WIDTH  signed quotient; held until next accept
//   remainder  out  WIDTH  signed remainder (sign of dividend); held until next accept
//   div_zero   out  1      sticky flag for last op: divisor was 0; cleared on accept
// BEHAVIOUR
//   Reset (clear=0, any time, incl. mid-operation):
//     state=IDLE; busy=done=lo_en=hi_en=div_zero=0; quotient=remainder=0; iteration counter=0.
//   States: IDLE -> PREP -> ITER(xWIDTH) -> FIX -> DONE -> IDLE (or PREP if start).
//   Accept edge k (start=1, flush=0, state IDLE or DONE): latch operands; busy=1; state PREP.
//   PREP (edge k+1): record q_sign=dvd[MSB]^dvs[MSB], r_sign=dvd[MSB].
//     Form |dvd|, |dvs| as unsigned WIDTH bits (|MIN| = 2^(WIDTH-1) unsigned).
//     Clear WIDTH+1-bit partial remainder; counter=0.
//     Normal op: -> ITER.
//     divisor==0: quotient=remainder=all ones, div_zero=1, -> FIX (fix-up skipped).
//     dividend==MIN && divisor==-1: quotient=MAX (0x7FFFFFFF), remainder=0, -> FIX (fix-up skipped).
//   ITER (edges k+2..k+WIDTH+1), one bit per edge:
//     {R,Q} shifted left 1 (next dividend bit in); trial = R - |dvs| in WIDTH+1 bits.
//     trial negative: keep R, q bit=0; else R=trial, q bit=1.
//     counter++; after counter==WIDTH-1 -> FIX.
//   FIX (edge k+WIDTH+2 normal, k+2 special): negate Q if q_sign, R if r_sign (two's complement, WIDTH bits).
//     Drive quotient/remainder; done=lo_en=hi_en=1; busy=0; state DONE.
//   DONE: lasts exactly one cycle; done deasserts on next edge.
//     start in this cycle is accepted (back-to-back ops, no idle bubble).
//   Latency (accept edge -> done visible): normal WIDTH+2 = 34 edges; special cases 2 edges.
//   flush=1 in PREP/ITER/FIX: -> IDLE next edge; busy=0; no done pulse; outputs keep previous values.
//     flush in IDLE/DONE: -> IDLE; done still completes its single cycle.
//   start while busy: ignored; operand changes while busy: no effect.
//   Results exact for all pairs: |remainder| < |divisor|; dividend = quotient*divisor + remainder.
// TESTING
//   100 / 7 -> done after 34 edges, quotient=14, remainder=2, lo_en=hi_en=1 for exactly one cycle.
//   -100 / 7 -> quotient=-14 (0xFFFFFFF2), remainder=-2.
//   100 / -7 -> quotient=-14, remainder=2.
//   5 / 0 -> done after 2 edges; quotient=remainder=0xFFFFFFFF, div_zero=1.
//   0x80000000 / -1 -> quotient=0x7FFFFFFF, remainder=0, div_zero=0.
//   0x80000000 / 1 -> quotient=0x80000000, remainder=0.
//   Accept 50/3; flush at ITER cycle 10 -> no done pulse; busy low next cycle.
//     Then 9/2 -> quotient=4, remainder=1.
//   Reset mid-operation: clear low at ITER cycle 20 -> all outputs 0 immediately.
//     After release, state IDLE; next op correct.
//   Back-to-back: start held high through DONE.
//     Second op accepted on done cycle; its done follows 34 edges later.
//     Start pulses while busy are ignored.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed divider sequencer: restoring shift/subtract, one quotient bit per clock,
// quotient to LO and remainder to HI with a single-cycle write-enable pulse.
module div_seq_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             lo_en,
   output logic             hi_en,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MaxVal = {1'b0, {(WIDTH-1){1'b1}}};

   typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
   logic [WIDTH-1:0] abs_dvs_q, abs_dvs_d;
   logic [WIDTH-1:0] acc_q, acc_d;   // dividend bits shifting out, quotient bits shifting in
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             q_sign_q, q_sign_d, r_sign_q, r_sign_d;
   logic             skip_q, skip_d;
   logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
   logic             div_zero_q, div_zero_d;

   logic             accept;
   logic [WIDTH:0]   rem_sh, trial;

   always_comb begin
      state_d     = state_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      abs_dvs_d   = abs_dvs_q;
      acc_d       = acc_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      q_sign_d    = q_sign_q;
      r_sign_d    = r_sign_q;
      skip_d      = skip_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      rem_sh      = {rem_q, acc_q[WIDTH-1]};
      trial       = rem_sh - {1'b0, abs_dvs_q};
      accept      = start && !flush && (state_q == StIdle || state_q == StDone);

      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (accept) begin
               dvd_d      = dividend;
               dvs_d      = divisor;
               div_zero_d = 1'b0;
               state_d    = StPrep;
            end
         end
         StPrep: begin
            q_sign_d  = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
            r_sign_d  = dvd_q[WIDTH-1];
            acc_d     = dvd_q[WIDTH-1] ? (WIDTH'(0) - dvd_q) : dvd_q;
            abs_dvs_d = dvs_q[WIDTH-1] ? (WIDTH'(0) - dvs_q) : dvs_q;
            rem_d     = '0;
            cnt_d     = '0;
            skip_d    = 1'b0;
            state_d   = StIter;
            if (dvs_q == '0) begin
               acc_d      = '1;
               rem_d      = '1;
               div_zero_d = 1'b1;
               skip_d     = 1'b1;
               state_d    = StFix;
            end else if (dvd_q == MinVal && dvs_q == '1) begin
               acc_d   = MaxVal;
               skip_d  = 1'b1;
               state_d = StFix;
            end
            if (flush) state_d = StIdle;
         end
         StIter: begin
            if (trial[WIDTH]) begin
               rem_d = rem_sh[WIDTH-1:0];
               acc_d = {acc_q[WIDTH-2:0], 1'b0};
            end else begin
               rem_d = trial[WIDTH-1:0];
               acc_d = {acc_q[WIDTH-2:0], 1'b1};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH-1)) state_d = StFix;
            if (flush) state_d = StIdle;
         end
         StFix: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               quotient_d  = (q_sign_q && !skip_q) ? (WIDTH'(0) - acc_q) : acc_q;
               remainder_d = (r_sign_q && !skip_q) ? (WIDTH'(0) - rem_q) : rem_q;
               state_d     = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q     <= StIdle;
         dvd_q       <= '0;
         dvs_q       <= '0;
         abs_dvs_q   <= '0;
         acc_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         q_sign_q    <= 1'b0;
         r_sign_q    <= 1'b0;
         skip_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         abs_dvs_q   <= abs_dvs_d;
         acc_q       <= acc_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         q_sign_q    <= q_sign_d;
         r_sign_q    <= r_sign_d;
         skip_q      <= skip_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign busy      = (state_q == StPrep) || (state_q == StIter) || (state_q == StFix);
   assign done      = (state_q == StDone);
   assign lo_en     = done;
   assign hi_en     = done;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

endmodule
